sa_cache_wb: RTL and testbench
==============================

# sa_cache_wb

Parametrised N-way set-associative write-back cache controller that sits between the CPU load/store port and the backing RAM. It generalises the current write-through, round-robin cache_controller to configurable width, sets and ways. It adds true-LRU replacement, dirty-line write-back, a ready/valid CPU handshake, a stallable memory port and hit/miss counters. Lines are one word; addresses are word addresses.

## Interface
- ADDR_W, 16, word address width
- DATA_W, 32, data word width
- NUM_SETS, 64, sets; power of two, >= 2
- NUM_WAYS, 4, ways per set; power of two, >= 2
- IDX_W, log2(NUM_SETS), derived; index = cpu_addr[IDX_W-1:0], tag = cpu_addr[ADDR_W-1:IDX_W]
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- cpu_req  in  1  request valid; held by requester until accepted
- cpu_we  in  1  1 = write, 0 = read; qualified by cpu_req
- cpu_addr  in  ADDR_W  request word address
- cpu_wdata  in  DATA_W  write data
- cpu_ready  out  1  controller idle; request accepted on edge where cpu_req && cpu_ready
- cpu_rvalid  out  1  one-cycle pulse, read data valid
- cpu_rdata  out  DATA_W  read data, valid while cpu_rvalid
- mem_req  out  1  memory request, held until mem_ready sampled high
- mem_we  out  1  1 = write-back, 0 = refill read
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  write-back data
- mem_ready  in  1  memory completes current request on this edge
- mem_rdata  in  DATA_W  refill data, sampled with mem_ready
- hit_count  out  16  saturating hit counter
- miss_count  out  16  saturating miss counter

## Operation
- State per line: valid, dirty, tag, data, age (log2(NUM_WAYS) bits).
- FSM states:
  - IDLE: cpu_ready=1; on accept, latch we/addr/wdata, go to LOOKUP.
  - LOOKUP: compare tag across the set.
    - Hit: read drives cpu_rdata and pulses cpu_rvalid; write updates data and sets dirty. Either way, update LRU, increment hit_count, go to IDLE.
    - Miss: increment miss_count and select a victim. If the victim is valid and dirty, go to WRITEBACK. Otherwise a read goes to REFILL and a write goes to INSTALL.
  - WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index}, mem_wdata=victim data. On mem_ready, a read goes to REFILL and a write goes to INSTALL.
  - REFILL: mem_req=1, mem_we=0, mem_addr=latched addr. On mem_ready, install mem_rdata clean, drive cpu_rdata and pulse cpu_rvalid, go to IDLE.
  - INSTALL (write miss, write-allocate, no fetch): write cpu_wdata into the victim with valid=1, dirty=1, new tag. Takes one cycle, then IDLE.
- Victim selection: lowest-index invalid way; if none, the way with age == NUM_WAYS-1.
- LRU update on every hit or install of way w with age a:
  - every way in the set with age < a increments;
  - way w gets age 0;
  - ages in a set stay a permutation of 0..NUM_WAYS-1.
- Counters saturate at 0xFFFF and do not wrap.
- Requests presented while cpu_ready=0 are ignored; no error is raised.
- Reset, from any state:
  - state -> IDLE; all valid and dirty bits -> 0; way w age -> w.
  - Counters -> 0.
  - Outputs: cpu_ready=1, cpu_rvalid=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset mid-WRITEBACK/REFILL abandons the transaction; dirty data is lost. The data array is not cleared.

## Timing
- Accept at edge T.
  - Read hit: cpu_rvalid and cpu_rdata valid after edge T+1 (2-edge latency, same as the current cache). cpu_ready is high again after T+1, so the next accept can occur at T+2.
  - Write hit: array updated at edge T+1.
- Read miss, clean victim: mem_req rises after T+1. If mem_ready is sampled at edge M, cpu_rvalid is high after M.
- Read miss, dirty victim: the write-back completes first. The refill mem_req asserts the cycle after the write-back mem_ready edge.
- Write miss: install at the edge after LOOKUP (or after the write-back completes); cpu_ready returns after that edge.
- Handshake stability: mem_req, mem_we, mem_addr and mem_wdata are registered and stay stable while mem_req=1 && mem_ready=0. mem_req drops the cycle after the mem_ready edge.
- cpu_rvalid is never high for more than one cycle per read.

## Test plan
- Cold read 0x0004, memory returns 0x12345678 after 3 cycles:
  - expect a refill with mem_addr 0x0004, mem_we=0;
  - cpu_rvalid with 0x12345678; miss_count=1, hit_count=0.
- Write 0x0004=0x1111AAAA, then read 0x0004:
  - no mem_req for either access;
  - cpu_rvalid after the 2nd edge with 0x1111AAAA.
- Fill one set and evict the LRU line:
  - write 0x0004/0x0404/0x0804/0x0C04 = 0xAAAA0001..4, read 0x0004, then write 0x1004=0xAAAA0005;
  - expect a write-back with mem_addr 0x0404, mem_wdata 0xAAAA0002;
  - a following read of 0x1004 hits with 0xAAAA0005; a read of 0x0404 misses and refills.
- Boundary: write 0xFFFF=0xDEADBEEF, then read 0xFFFF:
  - set 63, tag 0x3FF; hit returns 0xDEADBEEF;
  - a read of 0x003F (same set, other tag) misses.
- Memory stall: hold mem_ready low for 10 cycles during a refill:
  - mem_req, mem_addr and mem_we stay stable; cpu_ready=0;
  - cpu_req toggling during the stall is ignored.
- Reset mid-REFILL with rst_n low for 1 cycle:
  - after the edge: mem_req=0, cpu_ready=1, counters 0;
  - a read of 0x0004 (previously cached) misses.

Source files
------------

// File: rtl/sa_cache_wb.sv
// rtl/sa_cache_wb.sv - N-way set-associative write-back cache with true-LRU replacement
module sa_cache_wb #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int NUM_SETS = 64,
    parameter int NUM_WAYS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int WAY_W = $clog2(NUM_WAYS);

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL, S_INSTALL} state_t;
    state_t state, state_nx;

    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
    logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
    logic [DATA_W-1:0]   data_q  [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]    age_q   [NUM_SETS][NUM_WAYS];

    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [WAY_W-1:0]  vic_way;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] req_tag;
    assign idx     = req_addr[IDX_W-1:0];
    assign req_tag = req_addr[ADDR_W-1:IDX_W];

    logic             hit, has_inv, vic_dirty, upd_en;
    logic [WAY_W-1:0] hit_way, victim, upd_way, upd_age;

    // Tag match and victim choice: first invalid way, otherwise the oldest way.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        victim  = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[idx][w] && tag_q[idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!has_inv && !valid_q[idx][w]) begin
                has_inv = 1'b1;
                victim  = WAY_W'(w);
            end
        end
        if (!has_inv) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (age_q[idx][w] == WAY_W'(NUM_WAYS - 1)) victim = WAY_W'(w);
            end
        end
        vic_dirty = valid_q[idx][victim] && dirty_q[idx][victim];
    end

    always_comb begin
        upd_en  = 1'b0;
        upd_way = vic_way;
        if (state == S_LOOKUP && hit) begin
            upd_en  = 1'b1;
            upd_way = hit_way;
        end else if (state == S_INSTALL || (state == S_REFILL && mem_ready)) begin
            upd_en = 1'b1;
        end
        upd_age = age_q[idx][upd_way];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:      if (cpu_req) state_nx = S_LOOKUP;
            S_LOOKUP: begin
                if (hit)            state_nx = S_IDLE;
                else if (vic_dirty) state_nx = S_WRITEBACK;
                else if (req_we)    state_nx = S_INSTALL;
                else                state_nx = S_REFILL;
            end
            S_WRITEBACK: if (mem_ready) state_nx = req_we ? S_INSTALL : S_REFILL;
            S_REFILL:    if (mem_ready) state_nx = S_IDLE;
            S_INSTALL:   state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_ready = (state == S_IDLE);
        mem_req   = (state == S_WRITEBACK) || (state == S_REFILL);
        mem_we    = (state == S_WRITEBACK);
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == S_WRITEBACK) begin
            mem_addr  = wb_addr;
            mem_wdata = wb_data;
        end else if (state == S_REFILL) begin
            mem_addr = req_addr;
        end
    end

    // The data array is deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= WAY_W'(w);
            end
            req_we     <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            vic_way    <= '0;
            wb_addr    <= '0;
            wb_data    <= '0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            cpu_rvalid <= 1'b0;
            if (state == S_IDLE && cpu_req) begin
                req_we    <= cpu_we;
                req_addr  <= cpu_addr;
                req_wdata <= cpu_wdata;
            end
            if (state == S_LOOKUP) begin
                if (hit) begin
                    if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
                    if (req_we) begin
                        data_q[idx][hit_way]  <= req_wdata;
                        dirty_q[idx][hit_way] <= 1'b1;
                    end else begin
                        cpu_rvalid <= 1'b1;
                        cpu_rdata  <= data_q[idx][hit_way];
                    end
                end else begin
                    if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
                    vic_way <= victim;
                    wb_addr <= {tag_q[idx][victim], idx};
                    wb_data <= data_q[idx][victim];
                end
            end
            if (state == S_INSTALL) begin
                data_q[idx][vic_way]  <= req_wdata;
                tag_q[idx][vic_way]   <= req_tag;
                valid_q[idx][vic_way] <= 1'b1;
                dirty_q[idx][vic_way] <= 1'b1;
            end
            if (state == S_REFILL && mem_ready) begin
                data_q[idx][vic_way]  <= mem_rdata;
                tag_q[idx][vic_way]   <= req_tag;
                valid_q[idx][vic_way] <= 1'b1;
                dirty_q[idx][vic_way] <= 1'b0;
                cpu_rvalid            <= 1'b1;
                cpu_rdata             <= mem_rdata;
            end
            // Ages younger than the touched way shift up; the touched way becomes youngest.
            if (upd_en) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (age_q[idx][w] < upd_age) age_q[idx][w] <= age_q[idx][w] + WAY_W'(1);
                end
                age_q[idx][upd_way] <= '0;
            end
        end
    end
endmodule

// File: tb/tb_sa_cache_wb.sv
// tb/tb_sa_cache_wb.sv - directed self-checking bench for sa_cache_wb
module tb_sa_cache_wb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [15:0] hit_count, miss_count;

    int n_tests = 0;
    int n_fail  = 0;

    sa_cache_wb dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
    } mem_txn_t;

    mem_txn_t    mem_log[$];
    logic [31:0] mem_model [logic [15:0]];
    int          mem_delay = 0;
    logic        mem_hold  = 1'b0;

    // Backing memory: completes a request after mem_delay stalled cycles.
    initial begin
        int wait_cnt;
        mem_txn_t t;
        wait_cnt  = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (mem_req && !mem_hold) begin
                wait_cnt++;
                if (wait_cnt > mem_delay) begin
                    wait_cnt  = 0;
                    mem_ready = 1'b1;
                    t.we = mem_we; t.addr = mem_addr; t.wdata = mem_wdata;
                    mem_log.push_back(t);
                    if (mem_we) mem_model[mem_addr] = mem_wdata;
                    else mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output int lat, output logic ok);
        int n;
        ok = 1'b0; lat = 0; rdata = '0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        n = 0;
        while (!cpu_ready && n < 200) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        if (n >= 200) return;
        while (lat < 200) begin
            @(posedge clk); #1; lat++;
            if (!we && cpu_rvalid) begin rdata = cpu_rdata; ok = 1'b1; break; end
            if (we && cpu_ready)   begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if (cpu_ready !== 1'b1 || cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_cpu: ready=%b rvalid=%b rdata=%h, want 1 0 0", cpu_ready, cpu_rvalid, cpu_rdata);
        end
        n_tests++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mem: req=%b we=%b addr=%h wdata=%h, want all 0", mem_req, mem_we, mem_addr, mem_wdata);
        end
        n_tests++;
        if (hit_count !== 16'h0 || miss_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_cnt: hit=%0d miss=%0d, want 0 0", hit_count, miss_count);
        end
    endtask

    task automatic test_cold_read();
        logic [31:0] rd; int lat; logic ok;
        mem_delay = 2;
        mem_model[16'h0004] = 32'h12345678;
        cpu_access(1'b0, 16'h0004, 32'h0, rd, lat, ok);
        mem_delay = 0;
        n_tests++;
        if (ok !== 1'b1 || rd !== 32'h12345678 || lat != 4) begin
            n_fail++;
            $display("FAIL cold_read: ok=%b rdata=%h lat=%0d, want 1 12345678 4", ok, rd, lat);
        end
        n_tests++;
        if (mem_log.size() != 1 || mem_log[0].we !== 1'b0 || mem_log[0].addr !== 16'h0004) begin
            n_fail++;
            $display("FAIL cold_refill: txns=%0d, want one read of 0004", mem_log.size());
        end
        n_tests++;
        if (hit_count !== 16'd0 || miss_count !== 16'd1) begin
            n_fail++;
            $display("FAIL cold_cnt: hit=%0d miss=%0d, want 0 1", hit_count, miss_count);
        end
    endtask

    task automatic test_write_read_hit();
        logic [31:0] rd; int lat; logic ok; int log0;
        log0 = mem_log.size();
        cpu_access(1'b1, 16'h0004, 32'h1111AAAA, rd, lat, ok);
        n_tests++;
        if (ok !== 1'b1 || lat != 1) begin
            n_fail++;
            $display("FAIL write_hit: ok=%b lat=%0d, want 1 1", ok, lat);
        end
        cpu_access(1'b0, 16'h0004, 32'h0, rd, lat, ok);
        n_tests++;
        if (ok !== 1'b1 || rd !== 32'h1111AAAA || lat != 1) begin
            n_fail++;
            $display("FAIL read_hit: ok=%b rdata=%h lat=%0d, want 1 1111AAAA 1", ok, rd, lat);
        end
        @(posedge clk); #1;
        n_tests++;
        if (cpu_rvalid !== 1'b0 || mem_log.size() != log0) begin
            n_fail++;
            $display("FAIL hit_quiet: rvalid=%b new_txns=%0d, want 0 0", cpu_rvalid, mem_log.size() - log0);
        end
        n_tests++;
        if (hit_count !== 16'd2 || miss_count !== 16'd1) begin
            n_fail++;
            $display("FAIL hit_cnt: hit=%0d miss=%0d, want 2 1", hit_count, miss_count);
        end
    endtask

    task automatic test_lru_evict();
        logic [31:0] rd; int lat; logic ok; int log0;
        cpu_access(1'b1, 16'h0004, 32'hAAAA0001, rd, lat, ok);
        cpu_access(1'b1, 16'h0404, 32'hAAAA0002, rd, lat, ok);
        cpu_access(1'b1, 16'h0804, 32'hAAAA0003, rd, lat, ok);
        cpu_access(1'b1, 16'h0C04, 32'hAAAA0004, rd, lat, ok);
        cpu_access(1'b0, 16'h0004, 32'h0, rd, lat, ok);
        n_tests++;
        if (ok !== 1'b1 || rd !== 32'hAAAA0001) begin
            n_fail++;
            $display("FAIL fill_read: ok=%b rdata=%h, want 1 AAAA0001", ok, rd);
        end
        log0 = mem_log.size();
        cpu_access(1'b1, 16'h1004, 32'hAAAA0005, rd, lat, ok);
        n_tests++;
        if (ok !== 1'b1 || mem_log.size() != log0 + 1) begin
            n_fail++;
            $display("FAIL evict_txns: ok=%b new_txns=%0d, want 1 1", ok, mem_log.size() - log0);
        end else begin
            n_tests++;
            if (mem_log[log0].we !== 1'b1 || mem_log[log0].addr !== 16'h0404 || mem_log[log0].wdata !== 32'hAAAA0002) begin
                n_fail++;
                $display("FAIL evict_wb: we=%b addr=%h wdata=%h, want 1 0404 AAAA0002",
                         mem_log[log0].we, mem_log[log0].addr, mem_log[log0].wdata);
            end
        end
        log0 = mem_log.size();
        cpu_access(1'b0, 16'h1004, 32'h0, rd, lat, ok);
        n_tests++;
        if (ok !== 1'b1 || rd !== 32'hAAAA0005 || lat != 1 || mem_log.size() != log0) begin
            n_fail++;
            $display("FAIL new_line_hit: ok=%b rdata=%h lat=%0d, want 1 AAAA0005 1", ok, rd, lat);
        end
        // Way holding 0x0804 is now oldest and dirty, so it is written back before the refill.
        cpu_access(1'b0, 16'h0404, 32'h0, rd, lat, ok);
        n_tests++;
        if (ok !== 1'b1 || rd !== 32'hAAAA0002 || mem_log.size() != log0 + 2) begin
            n_fail++;
            $display("FAIL reread_evicted: ok=%b rdata=%h txns=%0d, want 1 AAAA0002 2", ok, rd, mem_log.size() - log0);
        end else begin
            n_tests++;
            if (mem_log[log0].we !== 1'b1 || mem_log[log0].addr !== 16'h0804 || mem_log[log0].wdata !== 32'hAAAA0003 ||
                mem_log[log0+1].we !== 1'b0 || mem_log[log0+1].addr !== 16'h0404) begin
                n_fail++;
                $display("FAIL reread_seq: wb=%h/%h refill=%h, want 0804/AAAA0003 0404",
                         mem_log[log0].addr, mem_log[log0].wdata, mem_log[log0+1].addr);
            end
        end
        n_tests++;
        if (hit_count !== 16'd5 || miss_count !== 16'd6) begin
            n_fail++;
            $display("FAIL lru_cnt: hit=%0d miss=%0d, want 5 6", hit_count, miss_count);
        end
    endtask

    task automatic test_boundary();
        logic [31:0] rd; int lat; logic ok; int log0;
        log0 = mem_log.size();
        mem_model[16'h003F] = 32'h0BAD003F;
        cpu_access(1'b1, 16'hFFFF, 32'hDEADBEEF, rd, lat, ok);
        n_tests++;
        if (ok !== 1'b1 || lat != 2 || mem_log.size() != log0) begin
            n_fail++;
            $display("FAIL top_install: ok=%b lat=%0d txns=%0d, want 1 2 0", ok, lat, mem_log.size() - log0);
        end
        cpu_access(1'b0, 16'hFFFF, 32'h0, rd, lat, ok);
        n_tests++;
        if (ok !== 1'b1 || rd !== 32'hDEADBEEF || lat != 1) begin
            n_fail++;
            $display("FAIL top_hit: ok=%b rdata=%h lat=%0d, want 1 DEADBEEF 1", ok, rd, lat);
        end
        cpu_access(1'b0, 16'h003F, 32'h0, rd, lat, ok);
        n_tests++;
        if (ok !== 1'b1 || rd !== 32'h0BAD003F || mem_log.size() != log0 + 1) begin
            n_fail++;
            $display("FAIL alias_miss: ok=%b rdata=%h txns=%0d, want 1 0BAD003F 1", ok, rd, mem_log.size() - log0);
        end
        n_tests++;
        if (hit_count !== 16'd6 || miss_count !== 16'd8) begin
            n_fail++;
            $display("FAIL boundary_cnt: hit=%0d miss=%0d, want 6 8", hit_count, miss_count);
        end
    endtask

    task automatic test_mem_stall();
        int n; int log0; logic [15:0] miss0;
        mem_delay = 10;
        mem_model[16'h0010] = 32'h5A5A0010;
        log0  = mem_log.size();
        miss0 = miss_count;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; cpu_wdata = '0;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        n = 0;
        while (!mem_req && n < 50) begin @(posedge clk); #1; n++; end
        n_tests++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0010 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_start: req=%b addr=%h we=%b, want 1 0010 0", mem_req, mem_addr, mem_we);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cpu_req = ~cpu_req; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 32'hBADBAD00;
            @(posedge clk); #1;
            n_tests++;
            if (mem_req !== 1'b1 || mem_addr !== 16'h0010 || mem_we !== 1'b0 || cpu_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: req=%b addr=%h we=%b ready=%b, want 1 0010 0 0",
                         i, mem_req, mem_addr, mem_we, cpu_ready);
            end
        end
        @(negedge clk);
        cpu_req = 1'b0;
        n = 0;
        while (!cpu_rvalid && n < 50) begin @(posedge clk); #1; n++; end
        n_tests++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h5A5A0010) begin
            n_fail++;
            $display("FAIL stall_data: rvalid=%b rdata=%h, want 1 5A5A0010", cpu_rvalid, cpu_rdata);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (mem_log.size() != log0 + 1 || miss_count !== miss0 + 16'd1 || cpu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_ignored: txns=%0d miss=%0d ready=%b, want 1 %0d 1",
                     mem_log.size() - log0, miss_count, cpu_ready, miss0 + 16'd1);
        end
        mem_delay = 0;
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] rd; int lat; logic ok; int n; int log0;
        mem_hold = 1'b1;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020; cpu_wdata = '0;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        n = 0;
        while (!mem_req && n < 50) begin @(posedge clk); #1; n++; end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (mem_req !== 1'b0 || cpu_ready !== 1'b1 || hit_count !== 16'd0 || miss_count !== 16'd0 || mem_addr !== 16'h0) begin
            n_fail++;
            $display("FAIL mid_reset: req=%b ready=%b hit=%0d miss=%0d addr=%h, want 0 1 0 0 0000",
                     mem_req, cpu_ready, hit_count, miss_count, mem_addr);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        mem_hold = 1'b0;
        log0 = mem_log.size();
        // Dirty 0xAAAA0001 at 0x0004 was never written back, so memory's copy returns.
        cpu_access(1'b0, 16'h0004, 32'h0, rd, lat, ok);
        n_tests++;
        if (ok !== 1'b1 || rd !== 32'h12345678 || miss_count !== 16'd1 || hit_count !== 16'd0 ||
            mem_log.size() != log0 + 1) begin
            n_fail++;
            $display("FAIL post_reset_miss: ok=%b rdata=%h miss=%0d hit=%0d txns=%0d, want 1 12345678 1 0 1",
                     ok, rd, miss_count, hit_count, mem_log.size() - log0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_cold_read();
        test_write_read_hit();
        test_lru_evict();
        test_boundary();
        test_mem_stall();
        test_reset_mid_refill();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
